serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-004 start  input  1  request to begin an addition; accepted only in IDLE.
REQ-005 a  input  WIDTH  operand A, sampled on the accepting edge only.
REQ-006 b  input  WIDTH  operand B, sampled on the accepting edge only.
REQ-007 cin  input  1  carry-in, sampled on the accepting edge only.
REQ-008 busy  output  1  high while bits are being processed.
REQ-009 done  output  1  one-cycle pulse marking sum/cout valid.
REQ-010 sum  output  WIDTH  registered result, a+b+cin modulo 2^WIDTH.
REQ-011 cout  output  1  registered carry-out of the WIDTH-bit addition.

Function
REQ-012 Bit-serial ripple addition shall be used: one full-adder bit per cycle, LSB first; no WIDTH-wide adder.
REQ-013 FSM states shall be IDLE, BUSY and DONE; all outputs shall be registered.
REQ-014 IDLE->BUSY on an edge with start=1: latch a, b and cin into operand shift registers and the carry register, clear the bit counter, and leave sum unchanged until the first BUSY bit.
REQ-015 Each BUSY edge shall compute s=a0^b0^c and c'=a0&b0 | c&(a0^b0), shift s into sum at the MSB (sum right-shifts), shift both operands right, and increment the counter.
REQ-016 The counter shall be $clog2(WIDTH) bits wide; on the edge processing bit WIDTH-1, the FSM shall go BUSY->DONE and load cout with the final carry.
REQ-017 Latency: with start accepted on edge E0, busy=1 from E0 to E_WIDTH, done=1 from E_WIDTH to E_WIDTH+1, and then DONE->IDLE unconditionally.
REQ-018 sum and cout shall hold their final values from E_WIDTH until the first BUSY bit of the next operation.
REQ-019 While busy shall not change, sum shall be a partial result; it shall be valid only when done=1 or in IDLE after a completed operation.
REQ-020 start in BUSY or DONE shall be ignored with no side effects; a, b and cin changes after acceptance shall not affect the result.
REQ-021 Back-to-back operation: start held high continuously shall begin a new addition on the first IDLE edge, giving a throughput of one result per WIDTH+2 cycles.
REQ-022 busy and done shall never be high simultaneously.

Reset
REQ-023 rst_n=0 at a rising edge shall force state=IDLE, busy=0, done=0, sum=0, cout=0, and clear the counter, shift registers and carry register.
REQ-024 Reset asserted mid-operation (BUSY or DONE) shall abort it: no done pulse, and sum=0 and cout=0 on the next edge.
REQ-025 start coincident with rst_n=0 shall be ignored.

Verification (WIDTH=8 unless stated)
REQ-026 a=0xFF, b=0x01, cin=0, start pulse -> busy for 8 cycles, done pulse on the 9th edge, sum=0x00, cout=1.
REQ-027 a=0x5A, b=0xA5, cin=1 -> sum=0x00, cout=1; with cin=0 -> sum=0xFF, cout=0.
REQ-028 start re-pulsed with a=0x11 during BUSY of a 0x03+0x04 operation -> ignored; result sum=0x07, cout=0, exactly one done pulse.
REQ-029 rst_n=0 on the 4th BUSY cycle -> no done pulse; busy=0, sum=0x00, cout=0 on the next edge, and a subsequent 0x10+0x20 gives 0x30.
REQ-030 start held high for 3 operations -> done pulses exactly 10 cycles apart, each result correct.
REQ-031 WIDTH=4, all 512 (a,b,cin) combinations -> {cout,sum} equals a+b+cin for every case.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder computing a + b + cin over WIDTH
// cycles, one full-adder bit per clock, LSB first.
//
// Ports:
//   clk    - sole clock, rising edge
//   rst_n  - synchronous active-low reset
//   start  - begin an addition (accepted only when idle)
//   a, b   - WIDTH-bit operands, captured on the accepting edge
//   cin    - carry-in, captured on the accepting edge
//   busy   - high while bits are being processed
//   done   - one-cycle pulse, sum/cout valid
//   sum    - registered WIDTH-bit result (partial while busy)
//   cout   - registered carry-out of the addition
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned   CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             s_bit;
   logic             c_next;

   // Single full-adder cell fed by the operand LSBs and the carry register.
   always_comb begin
      s_bit  = a_sr[0] ^ b_sr[0] ^ carry;
      c_next = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         a_sr  <= '0;
         b_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= BUSY;
               end
            end
            BUSY: begin
               // Result bits enter at the MSB; after WIDTH shifts the
               // first-computed bit has reached bit 0.
               sum   <= {s_bit, sum[WIDTH-1:1]};
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               carry <= c_next;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  cout  <= c_next;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed bench for serial_adder with an 8-bit instance
// and a 4-bit instance swept over every operand/carry combination.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       start8;
   logic [7:0] a8, b8;
   logic       cin8;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;

   logic       start4;
   logic [3:0] a4, b4;
   logic       cin4;
   logic       busy4, done4, cout4;
   logic [3:0] sum4;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, sample 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      check("busy_done_excl8", {31'b0, busy8 & done8}, 32'd0);
      check("busy_done_excl4", {31'b0, busy4 & done4}, 32'd0);
   endtask

   // Start an 8-bit op, return edges from acceptance to done (-1 on timeout).
   // Leaves the bench just after the done edge.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       output int lat);
      a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
      tick();
      check("busy_at_e0", {31'b0, busy8}, 32'd1);
      start8 = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (done8) begin
            lat = i;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int pulses;
      int done_edge;
      int k;
      int n;
      int done_at[3];
      logic [7:0] ea [3];
      logic [7:0] eb [3];
      logic       ec [3];
      logic [7:0] es [3];
      logic       eo [3];
      logic [4:0] e4;

      #1000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int lat;
      int pulses;
      int done_edge;
      int k;
      int n;
      int done_at[3];
      logic [7:0] ea [3];
      logic [7:0] eb [3];
      logic       ec [3];
      logic [7:0] es [3];
      logic       eo [3];
      logic [4:0] e4;

      rst_n = 1'b0;
      start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      start4 = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;

      // Reset with start asserted: start must be ignored.
      tick();
      tick();
      check("rst_busy", {31'b0, busy8}, 32'd0);
      check("rst_done", {31'b0, done8}, 32'd0);
      check("rst_sum", {24'b0, sum8}, 32'd0);
      check("rst_cout", {31'b0, cout8}, 32'd0);
      check("rst_busy4", {31'b0, busy4}, 32'd0);
      start8 = 1'b0; start4 = 1'b0;
      rst_n = 1'b1;
      tick();
      check("idle_after_rst", {31'b0, busy8}, 32'd0);

      // 0xFF + 0x01: carry ripples through every bit.
      run8(8'hFF, 8'h01, 1'b0, lat);
      check("ff01_latency", lat, 32'd8);
      check("ff01_sum", {24'b0, sum8}, 32'h00);
      check("ff01_cout", {31'b0, cout8}, 32'd1);
      check("ff01_busy_low", {31'b0, busy8}, 32'd0);
      tick();
      check("ff01_done_pulse_end", {31'b0, done8}, 32'd0);

      // Reset on the 4th busy cycle aborts the operation.
      a8 = 8'h55; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick();
      tick();
      tick();
      check("abort_partial_busy", {31'b0, busy8}, 32'd1);
      rst_n = 1'b0;
      tick();
      check("abort_busy", {31'b0, busy8}, 32'd0);
      check("abort_done", {31'b0, done8}, 32'd0);
      check("abort_sum", {24'b0, sum8}, 32'h00);
      check("abort_cout", {31'b0, cout8}, 32'd0);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done8) pulses++;
      end
      check("abort_no_done", pulses, 32'd0);
      run8(8'h10, 8'h20, 1'b0, lat);
      check("post_abort_latency", lat, 32'd8);
      check("post_abort_sum", {24'b0, sum8}, 32'h30);
      check("post_abort_cout", {31'b0, cout8}, 32'd0);
      tick();

      // 0x5A + 0xA5 with both carry-in values.
      run8(8'h5A, 8'hA5, 1'b1, lat);
      check("5aa5c1_latency", lat, 32'd8);
      check("5aa5c1_sum", {24'b0, sum8}, 32'h00);
      check("5aa5c1_cout", {31'b0, cout8}, 32'd1);
      tick();
      run8(8'h5A, 8'hA5, 1'b0, lat);
      check("5aa5c0_latency", lat, 32'd8);
      check("5aa5c0_sum", {24'b0, sum8}, 32'hFF);
      check("5aa5c0_cout", {31'b0, cout8}, 32'd0);
      a8 = 8'h00; b8 = 8'h00; cin8 = 1'b1;
      tick();
      tick();
      tick();
      check("hold_sum_idle", {24'b0, sum8}, 32'hFF);
      check("hold_cout_idle", {31'b0, cout8}, 32'd0);

      // Start re-pulsed during busy and operands changed after acceptance.
      a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick();
      tick();
      a8 = 8'h11; b8 = 8'h11; cin8 = 1'b1; start8 = 1'b1;
      tick();
      start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
      pulses = 0;
      done_edge = -1;
      for (int e = 4; e < 20; e++) begin
         tick();
         if (done8) begin
            pulses++;
            if (done_edge < 0) done_edge = e;
         end
      end
      check("ignore_start_pulses", pulses, 32'd1);
      check("ignore_start_edge", done_edge, 32'd8);
      check("ignore_start_sum", {24'b0, sum8}, 32'h07);
      check("ignore_start_cout", {31'b0, cout8}, 32'd0);

      // Start held high: three back-to-back operations.
      ea[0] = 8'h33; eb[0] = 8'h44; ec[0] = 1'b0; es[0] = 8'h77; eo[0] = 1'b0;
      ea[1] = 8'hC8; eb[1] = 8'h64; ec[1] = 1'b1; es[1] = 8'h2D; eo[1] = 1'b1;
      ea[2] = 8'h80; eb[2] = 8'h80; ec[2] = 1'b0; es[2] = 8'h00; eo[2] = 1'b1;
      k = 0;
      a8 = ea[0]; b8 = eb[0]; cin8 = ec[0]; start8 = 1'b1;
      for (n = 1; n <= 40; n++) begin
         tick();
         if (done8) begin
            done_at[k] = n;
            check($sformatf("b2b_sum_%0d", k), {24'b0, sum8}, {24'b0, es[k]});
            check($sformatf("b2b_cout_%0d", k), {31'b0, cout8}, {31'b0, eo[k]});
            k++;
            if (k == 3) break;
            a8 = ea[k]; b8 = eb[k]; cin8 = ec[k];
         end
      end
      start8 = 1'b0;
      check("b2b_count", k, 32'd3);
      if (k == 3) begin
         check("b2b_first_done", done_at[0], 32'd9);
         check("b2b_gap_01", done_at[1] - done_at[0], 32'd10);
         check("b2b_gap_12", done_at[2] - done_at[1], 32'd10);
      end
      tick();
      tick();

      // 4-bit instance: every (a, b, cin) combination.
      for (int i = 0; i < 512; i++) begin
         logic [8:0] v;
         v = 9'(i);
         a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8];
         e4 = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
         start4 = 1'b1;
         tick();
         start4 = 1'b0;
         lat = -1;
         for (int j = 1; j <= 10; j++) begin
            tick();
            if (done4) begin
               lat = j;
               break;
            end
         end
         check($sformatf("w4_lat_%0d", i), lat, 32'd4);
         check($sformatf("w4_res_a%0h_b%0h_c%0d", a4, b4, cin4),
               {27'b0, cout4, sum4}, {27'b0, e4});
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
